// File: rtl/regfile_wr_arbiter_if.sv
// Write-port sharing bus for regfile_wr_arbiter.
// There are two requester channels (valid/ready/addr/data). The shared register-file
// write port is wr_en/wr_addr/wr_data. The pending mask and last_grant are status
// outputs for the read side.
// slave  : the arbiter (accepts requests, drives the write port and the status outputs)
// master : the environment (drives requests, observes the arbiter)
interface regfile_wr_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [31:0]   pending;
  logic          last_grant;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output wr_en, wr_addr, wr_data, pending, last_grant
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  wr_en, wr_addr, wr_data, pending, last_grant
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the single file_reg write port between two writeback requesters.
// Requester 0 is the ALU result and requester 1 is the load result.
// Each requester owns a one-entry slot. Full slots are arbitrated round-robin,
// but writes to the same register go oldest first. The winner is registered onto
// the write port.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - slave side of regfile_wr_arbiter_if:
//          req0/req1 valid/ready/addr/data, wr_en/wr_addr/wr_data,
//          pending (per-register outstanding-write mask), last_grant
module regfile_wr_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wr_arbiter_if.slave   bus
);

  logic          r_s0_full, r_s1_full;
  logic [AW-1:0] r_s0_addr, r_s1_addr;
  logic [DW-1:0] r_s0_data, r_s1_data;
  logic          r_s1_older;   // valid only while both slots are full
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic          r_last_grant;

  logic          w_grant0, w_grant1;
  logic          w_ready0, w_ready1;
  logic          w_fill0, w_fill1;
  logic          w_keep0, w_keep1;
  logic [31:0]   w_pending;

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_s0_full && r_s1_full) begin
      if (r_s0_addr == r_s1_addr) begin
        // Same destination: the older write must land first.
        w_grant1 = r_s1_older;
        w_grant0 = ~r_s1_older;
      end else begin
        // Round-robin: the requester that did not win last time wins now.
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
      end
    end else begin
      w_grant0 = r_s0_full;
      w_grant1 = r_s1_full;
    end
  end

  assign w_ready0 = rst & (~r_s0_full | w_grant0);
  assign w_ready1 = rst & (~r_s1_full | w_grant1);

  // Writes to x0 complete the handshake but never occupy a slot.
  assign w_fill0  = bus.req0_valid & w_ready0 & (bus.req0_addr != '0);
  assign w_fill1  = bus.req1_valid & w_ready1 & (bus.req1_addr != '0);
  assign w_keep0  = r_s0_full & ~w_grant0;
  assign w_keep1  = r_s1_full & ~w_grant1;

  always_comb begin
    w_pending = '0;
    if (r_s0_full) w_pending = w_pending | (32'(1) << r_s0_addr);
    if (r_s1_full) w_pending = w_pending | (32'(1) << r_s1_addr);
    if (r_wr_en)   w_pending = w_pending | (32'(1) << r_wr_addr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0_full    <= 1'b0;
      r_s1_full    <= 1'b0;
      r_s0_addr    <= '0;
      r_s1_addr    <= '0;
      r_s0_data    <= '0;
      r_s1_data    <= '0;
      r_s1_older   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_s0_full <= w_fill0 | w_keep0;
      r_s1_full <= w_fill1 | w_keep1;
      if (w_fill0) begin
        r_s0_addr <= bus.req0_addr;
        r_s0_data <= bus.req0_data;
      end
      if (w_fill1) begin
        r_s1_addr <= bus.req1_addr;
        r_s1_data <= bus.req1_data;
      end
      // fill0 and keep1 are exclusive with fill1, so a simultaneous fill
      // of both slots falls to the second branch (slot 0 older).
      if (w_fill0 && w_keep1)
        r_s1_older <= 1'b1;
      else if (w_fill1)
        r_s1_older <= 1'b0;

      r_wr_en <= w_grant0 | w_grant1;
      if (w_grant0) begin
        r_wr_addr    <= r_s0_addr;
        r_wr_data    <= r_s0_data;
        r_last_grant <= 1'b0;
      end else if (w_grant1) begin
        r_wr_addr    <= r_s1_addr;
        r_wr_data    <= r_s1_data;
        r_last_grant <= 1'b1;
      end
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.pending    = w_pending;
  assign bus.last_grant = r_last_grant;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_wr_arbiter_if #(.AW(5), .DW(32)) bus ();

  regfile_wr_arbiter #(.AW(5), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural file_reg fed by the write port.
  logic [31:0] rf [32];
  always @(posedge clk)
    if (rst && bus.wr_en && bus.wr_addr != 5'd0) rf[bus.wr_addr] <= bus.wr_data;

  // Reference model: each slot is an optional entry stamped with its accept cycle.
  logic        m_full [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  int          m_ts   [2];
  logic        m_last;
  logic        m_wen;
  logic [4:0]  m_waddr;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } wr_t;
  wr_t expq[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 1'b0;
      m_addr[i] = '0;
      m_data[i] = '0;
      m_ts[i]   = 0;
    end
    m_last  = 1'b1;
    m_wen   = 1'b0;
    m_waddr = '0;
    expq.delete();
  endfunction

  // Scoreboard monitor: every presented write must match the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.wr_en) begin
        if (expq.size() == 0) begin
          chk("spurious_write", {27'd0, bus.wr_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = expq.pop_front();
          chk("wr_addr", {27'd0, bus.wr_addr}, {27'd0, e.a});
          chk("wr_data", bus.wr_data, e.d);
          chk("wr_cycle", cyc, e.c);
        end
      end
    end
  end

  // One clock cycle: drive the inputs, check the state-derived outputs against the model,
  // then advance the model across the coming edge.
  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    int          g;
    logic        rdy0, rdy1;
    logic [31:0] pend;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    #1;
    g = -1;
    if (m_full[0] && m_full[1]) begin
      if (m_addr[0] == m_addr[1]) g = (m_ts[1] < m_ts[0]) ? 1 : 0;
      else                        g = m_last ? 0 : 1;
    end else if (m_full[0]) g = 0;
    else if (m_full[1])     g = 1;
    rdy0 = !m_full[0] || g == 0;
    rdy1 = !m_full[1] || g == 1;
    pend = '0;
    for (int i = 0; i < 2; i++) if (m_full[i]) pend[m_addr[i]] = 1'b1;
    if (m_wen) pend[m_waddr] = 1'b1;
    chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, rdy0});
    chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, rdy1});
    chk("pending", bus.pending, pend);
    chk("last_grant", {31'd0, bus.last_grant}, {31'd0, m_last});
    chk("wr_en", {31'd0, bus.wr_en}, {31'd0, m_wen});

    m_wen = (g >= 0);
    if (g >= 0) begin
      expq.push_back('{a: m_addr[g], d: m_data[g], c: cyc + 1});
      m_waddr   = m_addr[g];
      m_last    = (g == 1);
      m_full[g] = 1'b0;
    end
    if (v0 && rdy0 && a0 != 5'd0) begin
      m_full[0] = 1'b1; m_addr[0] = a0; m_data[0] = d0; m_ts[0] = cyc;
    end
    if (v1 && rdy1 && a1 != 5'd0) begin
      m_full[1] = 1'b1; m_addr[1] = a1; m_data[1] = d1; m_ts[1] = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h1;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'h2;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #11;
    chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("rst_pending", bus.pending, 32'd0);
    chk("rst_last_grant", {31'd0, bus.last_grant}, 32'd1);
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst = 1'b1;

    // Single write.
    step(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    idle(4);
    chk("rf5", rf[5], 32'h1234_5678);

    // Same-address ordering.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1);
    step(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0);
    idle(4);
    chk("rf7", rf[7], 32'h2);

    // Discarded x0 write.
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    idle(3);

    // Contention on different addresses.
    for (int i = 0; i < 8; i++) step(1'b1, 5'd2, 32'hA, 1'b1, 5'd10, 32'hB);

    // Reset mid-flight.
    @(negedge clk);
    chk("pre_rst_wr_en", {31'd0, bus.wr_en}, 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("mid_rst_pending", bus.pending, 32'd0);
    chk("mid_rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    model_reset();
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst = 1'b1;
    step(1'b1, 5'd12, 32'hC0DE_0000, 1'b1, 5'd13, 32'hC0DE_0001);
    idle(4);
    chk("post_rst_rf12", rf[12], 32'hC0DE_0000);

    // Randomized traffic over a small address range to exercise collisions and x0.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
    idle(6);
    chk("queue_drained", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
